// File: rtl/l1_cache_ctrl.sv
// Miss/refill sequencer for the 2-way L1 data cache: load-miss refills,
// write-through stores, saturating hit/miss counters and a sticky timeout flag.
module l1_cache_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             store_i,
    input  logic [31:0]      addr_i,
    input  logic [31:0]      wdata_i,
    input  logic             cache_hit_i,
    input  logic [31:0]      mem_rdata_i,
    input  logic             mem_ready_i,
    output logic             stall_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    output logic             refill_we_o,
    output logic [31:0]      refill_addr_o,
    output logic [31:0]      refill_data_o,
    output logic             err_o,
    output logic [CNT_W-1:0] hit_cnt_o,
    output logic [CNT_W-1:0] miss_cnt_o
);
    typedef enum logic [1:0] {IDLE, RD_REQ, REFILL, WR_REQ} state_t;

    localparam int                WAIT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              refill_we_q, refill_we_d;
    logic [31:0]       refill_addr_q, refill_addr_d;
    logic [31:0]       refill_data_q, refill_data_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // Gated by rst_n so a held store/miss cannot freeze the pipeline during reset.
    assign stall_o = rst_n & ((state_q != IDLE) | store_i | (load_i & ~cache_hit_i));

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        refill_we_d   = refill_we_q;
        refill_addr_d = refill_addr_q;
        refill_data_d = refill_data_q;
        err_d         = err_q;
        hit_cnt_d     = hit_cnt_q;
        miss_cnt_d    = miss_cnt_q;

        case (state_q)
            IDLE: begin
                if (store_i) begin
                    mem_addr_d  = addr_i;
                    mem_wdata_d = wdata_i;
                    mem_we_d    = 1'b1;
                    mem_req_d   = 1'b1;
                    wait_d      = '0;
                    state_d     = WR_REQ;
                end else if (load_i && !cache_hit_i) begin
                    mem_addr_d  = addr_i;
                    mem_we_d    = 1'b0;
                    mem_req_d   = 1'b1;
                    wait_d      = '0;
                    miss_cnt_d  = sat_inc(miss_cnt_q);
                    state_d     = RD_REQ;
                end else if (load_i) begin
                    hit_cnt_d   = sat_inc(hit_cnt_q);
                end
            end
            RD_REQ: begin
                // A ready arriving on the last allowed cycle still completes normally.
                if (mem_ready_i) begin
                    refill_data_d = mem_rdata_i;
                    refill_addr_d = mem_addr_q;
                    mem_req_d     = 1'b0;
                    refill_we_d   = 1'b1;
                    state_d       = REFILL;
                end else if (wait_q == WAIT_LAST) begin
                    mem_req_d     = 1'b0;
                    err_d         = 1'b1;
                    state_d       = IDLE;
                end else begin
                    wait_d        = wait_q + 1'b1;
                end
            end
            REFILL: begin
                refill_we_d = 1'b0;
                state_d     = IDLE;
            end
            WR_REQ: begin
                if (mem_ready_i) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = IDLE;
                end else if (wait_q == WAIT_LAST) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    err_d     = 1'b1;
                    state_d   = IDLE;
                end else begin
                    wait_d    = wait_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            wait_q        <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            refill_we_q   <= 1'b0;
            refill_addr_q <= '0;
            refill_data_q <= '0;
            err_q         <= 1'b0;
            hit_cnt_q     <= '0;
            miss_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            refill_we_q   <= refill_we_d;
            refill_addr_q <= refill_addr_d;
            refill_data_q <= refill_data_d;
            err_q         <= err_d;
            hit_cnt_q     <= hit_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
        end
    end

    assign mem_req_o     = mem_req_q;
    assign mem_we_o      = mem_we_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_wdata_o   = mem_wdata_q;
    assign refill_we_o   = refill_we_q;
    assign refill_addr_o = refill_addr_q;
    assign refill_data_o = refill_data_q;
    assign err_o         = err_q;
    assign hit_cnt_o     = hit_cnt_q;
    assign miss_cnt_o    = miss_cnt_q;
endmodule

// File: tb/tb_l1_cache_ctrl.sv
// Scoreboard bench for l1_cache_ctrl: memory requests and refills observed by a
// monitor are matched against expectations queued when stimulus is driven.
module tb_l1_cache_ctrl;
    localparam int TO = 8;
    localparam int CW = 3;

    logic          clk, rst_n, load_i, store_i, cache_hit_i, mem_ready_i;
    logic [31:0]   addr_i, wdata_i, mem_rdata_i;
    logic          stall_o, mem_req_o, mem_we_o, refill_we_o, err_o;
    logic [31:0]   mem_addr_o, mem_wdata_o, refill_addr_o, refill_data_o;
    logic [CW-1:0] hit_cnt_o, miss_cnt_o;

    l1_cache_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .load_i(load_i), .store_i(store_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .cache_hit_i(cache_hit_i),
        .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i),
        .stall_o(stall_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .refill_we_o(refill_we_o), .refill_addr_o(refill_addr_o),
        .refill_data_o(refill_data_o), .err_o(err_o),
        .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed { logic we; logic [31:0] addr; logic [31:0] wdata; } req_t;
    typedef struct packed { logic [31:0] addr; logic [31:0] data; } rf_t;

    int            n_checks = 0;
    int            n_pass   = 0;
    req_t          exp_req[$];
    rf_t           exp_rf[$];
    logic [CW-1:0] exp_hit, exp_miss;
    int            req_rd = 0;
    int            rf_rd  = 0;

    // Monitor: records each new memory request and each refill strobe.
    req_t obs_req [0:63];
    rf_t  obs_rf  [0:63];
    int   obs_req_n = 0;
    int   obs_rf_n  = 0;
    int   hold_err  = 0;
    int   rf_err    = 0;
    logic req_prev  = 1'b0;
    logic rf_prev   = 1'b0;
    req_t cur_req;

    always @(negedge clk) begin
        req_prev <= mem_req_o;
        rf_prev  <= refill_we_o;
        if (rst_n) begin
            if (mem_req_o && !req_prev) begin
                cur_req <= '{mem_we_o, mem_addr_o, mem_wdata_o};
                obs_req[obs_req_n[5:0]] <= '{mem_we_o, mem_addr_o, mem_wdata_o};
                obs_req_n <= obs_req_n + 1;
            end else if (mem_req_o && ({mem_we_o, mem_addr_o, mem_wdata_o} !== cur_req)) begin
                hold_err <= hold_err + 1;
            end
            if (refill_we_o) begin
                obs_rf[obs_rf_n[5:0]] <= '{refill_addr_o, refill_data_o};
                obs_rf_n <= obs_rf_n + 1;
                if (rf_prev) rf_err <= rf_err + 1;
            end
        end
    end

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + 1'b1;
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0; load_i = 1'b0; store_i = 1'b0; cache_hit_i = 1'b0; mem_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_hit = '0; exp_miss = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; store_i = 1'b1; load_i = 1'b1; cache_hit_i = 1'b0; mem_ready_i = 1'b0;
        addr_i = 32'h0; wdata_i = 32'h0; mem_rdata_i = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (stall_o !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall_o); else n_pass++;
        n_checks++;
        if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o} !== 66'h0)
            $display("FAIL reset_mem: got req=%b we=%b addr=%h wdata=%h want all 0",
                     mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o);
        else n_pass++;
        n_checks++;
        if ({refill_we_o, refill_addr_o, refill_data_o} !== 65'h0)
            $display("FAIL reset_refill: got we=%b addr=%h data=%h want all 0",
                     refill_we_o, refill_addr_o, refill_data_o);
        else n_pass++;
        n_checks++;
        if ({err_o, hit_cnt_o, miss_cnt_o} !== '0)
            $display("FAIL reset_status: got err=%b hit=%0d miss=%0d want 0", err_o, hit_cnt_o, miss_cnt_o);
        else n_pass++;
        store_i = 1'b0; load_i = 1'b0; rst_n = 1'b1;
        exp_hit = '0; exp_miss = '0;
        @(negedge clk);
        n_checks++;
        if ({stall_o, mem_req_o} !== 2'b00)
            $display("FAIL reset_idle: got stall=%b req=%b want 0 0", stall_o, mem_req_o);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_load_hit();
        int bad = 0;
        apply_reset();
        addr_i = 32'h80; load_i = 1'b1; cache_hit_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (stall_o !== 1'b0 || mem_req_o !== 1'b0) bad++;
            exp_hit = sat_inc(exp_hit);
            @(posedge clk); #1;
        end
        load_i = 1'b0; cache_hit_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bad != 0) $display("FAIL hit_nostall: got %0d bad cycles want 0", bad); else n_pass++;
        n_checks++;
        if (hit_cnt_o !== exp_hit) $display("FAIL hit_cnt: got %0d want %0d", hit_cnt_o, exp_hit); else n_pass++;
        n_checks++;
        if (obs_req_n != req_rd) $display("FAIL hit_noreq: got %0d requests want 0", obs_req_n - req_rd); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_load_miss(input logic [31:0] a, input logic [31:0] d, input int nwait);
        int   stalls = 0;
        int   reqc   = 0;
        bit   done   = 0;
        req_t er, orq;
        rf_t  ef, orf;
        exp_req.push_back('{1'b0, a, 32'h0});
        exp_rf.push_back('{a, d});
        exp_miss = sat_inc(exp_miss);
        exp_hit  = sat_inc(exp_hit);
        addr_i = a; load_i = 1'b1; cache_hit_i = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (!stall_o) done = 1;
            else begin
                stalls++;
                if (refill_we_o) cache_hit_i = 1'b1;
                mem_ready_i = mem_req_o && (reqc == nwait);
                mem_rdata_i = mem_ready_i ? d : ~d;
                if (mem_req_o) reqc++;
                @(posedge clk); #1;
                mem_ready_i = 1'b0;
            end
        end
        @(posedge clk); #1;
        load_i = 1'b0; cache_hit_i = 1'b0;
        n_checks++;
        if (!done) $display("FAIL miss_timeout: stall never released for addr %h", a); else n_pass++;
        n_checks++;
        if (stalls != 3 + nwait) $display("FAIL miss_stalls: got %0d want %0d", stalls, 3 + nwait); else n_pass++;
        @(negedge clk);
        n_checks++;
        if (miss_cnt_o !== exp_miss || hit_cnt_o !== exp_hit)
            $display("FAIL miss_counters: got hit=%0d miss=%0d want hit=%0d miss=%0d",
                     hit_cnt_o, miss_cnt_o, exp_hit, exp_miss);
        else n_pass++;
        er = exp_req.pop_front();
        n_checks++;
        if (req_rd >= obs_req_n) $display("FAIL miss_req: got none want read of %h", er.addr);
        else begin
            orq = obs_req[req_rd[5:0]]; req_rd++;
            if (orq.we !== er.we || orq.addr !== er.addr)
                $display("FAIL miss_req: got we=%b addr=%h want we=%b addr=%h", orq.we, orq.addr, er.we, er.addr);
            else n_pass++;
        end
        ef = exp_rf.pop_front();
        n_checks++;
        if (rf_rd >= obs_rf_n) $display("FAIL miss_refill: got none want addr=%h data=%h", ef.addr, ef.data);
        else begin
            orf = obs_rf[rf_rd[5:0]]; rf_rd++;
            if (orf !== ef)
                $display("FAIL miss_refill: got addr=%h data=%h want addr=%h data=%h",
                         orf.addr, orf.data, ef.addr, ef.data);
            else n_pass++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_store(input logic [31:0] a, input logic [31:0] d, input int nwait, input bit with_load);
        int   stalls = 0;
        int   reqc   = 0;
        bit   done   = 0;
        bit   fin;
        int   rf_before;
        req_t er, orq;
        rf_before = obs_rf_n;
        exp_req.push_back('{1'b1, a, d});
        addr_i = a; wdata_i = d; store_i = 1'b1; load_i = with_load; cache_hit_i = with_load;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (!stall_o) done = 1;
            else begin
                stalls++;
                fin = mem_req_o && (reqc == nwait);
                mem_ready_i = fin;
                if (mem_req_o) reqc++;
                @(posedge clk); #1;
                mem_ready_i = 1'b0;
                if (c == 0) begin addr_i = ~a; wdata_i = ~d; end
                if (fin) begin store_i = 1'b0; load_i = 1'b0; cache_hit_i = 1'b0; end
            end
        end
        store_i = 1'b0; load_i = 1'b0; cache_hit_i = 1'b0;
        n_checks++;
        if (!done || stalls != 2 + nwait)
            $display("FAIL store_stalls: got %0d (done=%0b) want %0d", stalls, done, 2 + nwait);
        else n_pass++;
        n_checks++;
        if (reqc != nwait + 1) $display("FAIL store_req_len: got %0d want %0d", reqc, nwait + 1); else n_pass++;
        n_checks++;
        if ({mem_req_o, mem_we_o} !== 2'b00 || hit_cnt_o !== exp_hit)
            $display("FAIL store_after: got req=%b we=%b hit=%0d want 0 0 %0d", mem_req_o, mem_we_o, hit_cnt_o, exp_hit);
        else n_pass++;
        er = exp_req.pop_front();
        n_checks++;
        if (req_rd >= obs_req_n) $display("FAIL store_req: got none want write of %h", er.addr);
        else begin
            orq = obs_req[req_rd[5:0]]; req_rd++;
            if (orq !== er)
                $display("FAIL store_req: got we=%b addr=%h wdata=%h want we=%b addr=%h wdata=%h",
                         orq.we, orq.addr, orq.wdata, er.we, er.addr, er.wdata);
            else n_pass++;
        end
        @(posedge clk); #1;
        n_checks++;
        if (obs_rf_n != rf_before) $display("FAIL store_norefill: got %0d refills want 0", obs_rf_n - rf_before); else n_pass++;
    endtask

    task automatic test_timeout();
        int reqc = 0;
        bit done = 0;
        apply_reset();
        exp_miss = sat_inc(exp_miss);
        addr_i = 32'h0000_0A00; load_i = 1'b1; cache_hit_i = 1'b0; mem_ready_i = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (mem_req_o) reqc++;
            else if (reqc > 0) begin done = 1; load_i = 1'b0; end
            if (!done) begin @(posedge clk); #1; end
        end
        #1;
        n_checks++;
        if (reqc != TO) $display("FAIL timeout_len: got %0d req cycles want %0d", reqc, TO); else n_pass++;
        n_checks++;
        if (err_o !== 1'b1 || stall_o !== 1'b0 || refill_we_o !== 1'b0)
            $display("FAIL timeout_state: got err=%b stall=%b refill=%b want 1 0 0", err_o, stall_o, refill_we_o);
        else n_pass++;
        n_checks++;
        if (req_rd >= obs_req_n || obs_req[req_rd[5:0]].addr !== 32'h0000_0A00 || obs_rf_n != rf_rd)
            $display("FAIL timeout_sb: got reqs=%0d refills=%0d want 1 read of 00000a00, 0 refills",
                     obs_req_n - req_rd, obs_rf_n - rf_rd);
        else n_pass++;
        if (req_rd < obs_req_n) req_rd++;
        n_checks++;
        if (miss_cnt_o !== exp_miss) $display("FAIL timeout_miss: got %0d want %0d", miss_cnt_o, exp_miss); else n_pass++;
        @(posedge clk); #1;
        test_store(32'h0000_0B00, 32'h1111_2222, 1, 1'b0);
        test_load_miss(32'h0000_0C00, 32'h3333_4444, 0);
        n_checks++;
        if (err_o !== 1'b1) $display("FAIL err_sticky: got %b want 1", err_o); else n_pass++;
    endtask

    task automatic test_timeout_edge();
        apply_reset();
        test_load_miss(32'h0000_0D00, 32'h5555_6666, TO - 1);
        n_checks++;
        if (err_o !== 1'b0) $display("FAIL timeout_edge_err: got %b want 0", err_o); else n_pass++;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        addr_i = 32'h0000_0E00; load_i = 1'b1; cache_hit_i = 1'b0; mem_ready_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (mem_req_o !== 1'b1) $display("FAIL rstmid_pre: got req=%b want 1", mem_req_o); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, refill_we_o, err_o, miss_cnt_o} !== '0)
            $display("FAIL rstmid_async: got stall=%b req=%b addr=%h miss=%0d want all 0",
                     stall_o, mem_req_o, mem_addr_o, miss_cnt_o);
        else n_pass++;
        @(posedge clk); #1;
        load_i = 1'b0; rst_n = 1'b1;
        exp_hit = '0; exp_miss = '0;
        n_checks++;
        if (req_rd >= obs_req_n || obs_req[req_rd[5:0]].addr !== 32'h0000_0E00)
            $display("FAIL rstmid_req: got %0d requests want 1 read of 00000e00", obs_req_n - req_rd);
        else n_pass++;
        if (req_rd < obs_req_n) req_rd++;
        @(posedge clk); #1;
        n_checks++;
        if (obs_rf_n != rf_rd || refill_we_o !== 1'b0)
            $display("FAIL rstmid_norefill: got %0d refills want 0", obs_rf_n - rf_rd);
        else n_pass++;
        test_load_miss(32'h0000_0300, 32'h1234_5678, 1);
    endtask

    task automatic test_saturation();
        apply_reset();
        addr_i = 32'h0000_0090; load_i = 1'b1; cache_hit_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            exp_hit = sat_inc(exp_hit);
        end
        load_i = 1'b0; cache_hit_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (hit_cnt_o !== exp_hit) $display("FAIL hit_sat: got %0d want %0d", hit_cnt_o, exp_hit); else n_pass++;
        @(posedge clk); #1;
        test_store(32'h0000_0040, 32'hA5A5_A5A5, 1, 1'b1);
        for (int i = 0; i < 9; i++)
            test_load_miss(32'h0000_0400 + 32'(i * 4), 32'h0F00_0000 + 32'(i), i % 2);
    endtask

    task automatic test_back_to_back();
        apply_reset();
        test_store(32'h0000_0020, 32'h0000_0055, 0, 1'b0);
        test_load_miss(32'h0000_0104, 32'hDEAD_BEEF, 2);
        test_store(32'h0000_1000, 32'hCAFE_F00D, 3, 1'b0);
        test_load_miss(32'h0000_2000, 32'h0BAD_F00D, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        exp_hit = '0; exp_miss = '0;
        test_reset();
        test_load_hit();
        apply_reset();
        test_load_miss(32'h0000_0104, 32'hDEAD_BEEF, 2);
        apply_reset();
        test_store(32'h0000_0020, 32'h0000_0055, 0, 1'b0);
        test_back_to_back();
        test_timeout();
        test_timeout_edge();
        test_reset_mid();
        test_saturation();
        n_checks++;
        if (hold_err != 0 || rf_err != 0)
            $display("FAIL hold_stable: got hold_err=%0d refill_len_err=%0d want 0 0", hold_err, rf_err);
        else n_pass++;
        n_checks++;
        if (obs_req_n != req_rd || obs_rf_n != rf_rd || exp_req.size() != 0 || exp_rf.size() != 0)
            $display("FAIL sb_drain: got extra reqs=%0d refills=%0d want 0 0", obs_req_n - req_rd, obs_rf_n - rf_rd);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/l1_cache_ctrl.md
Name: l1_cache_ctrl

Overview:
- Miss/refill sequencer for the 2-way L1 data cache, placed between the memory-stage pipeline, the L1 cache array and the main data memory.
- Detects load misses and stalls the pipeline. Fetches the missing word from memory over a req/ready handshake, then writes it into the cache through a dedicated refill port.
- Stores are write-through: each store is forwarded to memory, with a stall until memory accepts it.
- Provides saturating hit/miss performance counters and a sticky memory-timeout error flag.

Parameters:
- TIMEOUT, 64: maximum cycles a memory request may wait for mem_ready_i before it is aborted.
- CNT_W, 16: width of the hit and miss performance counters.

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- load_i  in  1  memory-stage load valid (LoadM).
- store_i  in  1  memory-stage store valid (StoreM & memwriteM).
- addr_i  in  32  memory-stage byte address.
- wdata_i  in  32  store data.
- cache_hit_i  in  1  combinational hit from the L1 array for addr_i.
- mem_rdata_i  in  32  read data from main memory; valid when mem_ready_i=1.
- mem_ready_i  in  1  memory completion/acknowledge for the current request.
- stall_o  out  1  freezes the pipeline up to and including the memory stage.
- mem_req_o  out  1  memory request valid.
- mem_we_o  out  1  1 = write request, 0 = read request.
- mem_addr_o  out  32  latched request address.
- mem_wdata_o  out  32  latched store data.
- refill_we_o  out  1  one-cycle write strobe to the L1 refill port.
- refill_addr_o  out  32  address for the refill.
- refill_data_o  out  32  word to install in the cache.
- err_o  out  1  sticky: a memory request timed out.
- hit_cnt_o  out  CNT_W  saturating count of load hits.
- miss_cnt_o  out  CNT_W  saturating count of load misses.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE.
  - Outputs zero: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, refill_we_o, refill_addr_o, refill_data_o, err_o, hit_cnt_o, miss_cnt_o.
  - stall_o = 0 while rst_n = 0.
  - Reset mid-request abandons the request with no refill. Memory must tolerate a dropped mem_req_o.
- States: IDLE, RD_REQ, REFILL, WR_REQ.
- stall_o is combinational: (state != IDLE) | (state == IDLE & store_i) | (state == IDLE & load_i & !cache_hit_i).
- Consequence: stall is asserted in the same cycle a miss or store is presented, and deasserts in the cycle after REFILL or after the write completes.
- IDLE:
  - store_i = 1: latch addr_i → mem_addr_o and wdata_i → mem_wdata_o; set mem_we_o = 1 and mem_req_o = 1; go to WR_REQ. Store has priority; a simultaneous load_i is ignored and the pipeline re-presents it after the stall.
  - else load_i & !cache_hit_i: latch addr_i; set mem_we_o = 0 and mem_req_o = 1; miss_cnt_o += 1 (saturating); go to RD_REQ.
  - else load_i & cache_hit_i: hit_cnt_o += 1 (saturating); stay in IDLE with no stall.
- RD_REQ and WR_REQ:
  - mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o are held stable until a posedge samples mem_ready_i = 1.
  - A wait counter is cleared on entry and increments every cycle that mem_ready_i = 0.
- RD_REQ completion (mem_ready_i = 1):
  - Capture mem_rdata_i → refill_data_o and mem_addr_o → refill_addr_o.
  - mem_req_o ← 0, refill_we_o ← 1; go to REFILL.
- REFILL: refill_we_o is high for exactly this one cycle; then refill_we_o ← 0 and state ← IDLE. The replayed load then hits.
- WR_REQ completion (mem_ready_i = 1): mem_req_o ← 0, mem_we_o ← 0; go to IDLE. The cache itself performs the store-side update, so there is no refill.
- Minimum latencies:
  - Load miss: 3 stall cycles (miss-detect cycle, RD_REQ with immediate ready, REFILL).
  - Store: 2 stall cycles.
  - Each extra cycle of memory wait adds one stall cycle.
- Timeout: if the wait counter reaches TIMEOUT-1 with mem_ready_i still 0, then:
  - mem_req_o ← 0, err_o ← 1 (sticky until reset), state ← IDLE, no refill.
  - A mem_ready_i in that same cycle wins: the request completes normally and err_o is not set.
- mem_ready_i outside RD_REQ/WR_REQ is ignored.
- Counters saturate at 2^CNT_W - 1 and never wrap. They increment only in IDLE; stall cycles do not recount a held load.

Test Plan:
- Load hit: load_i=1, cache_hit_i=1 for 4 cycles → stall_o=0 throughout, hit_cnt_o=4, mem_req_o never asserted.
- Load miss, memory ready after 2 wait cycles, addr 0x0000_0104, rdata 0xDEAD_BEEF → stall high for 5 cycles; one-cycle refill_we_o with refill_addr_o=0x104 and refill_data_o=0xDEADBEEF; miss_cnt_o=1; then a hit with no stall.
- Store to 0x20 with data 0x55, immediate ready → mem_req_o & mem_we_o high for 1 cycle with mem_addr_o=0x20 and mem_wdata_o=0x55; stall 2 cycles; refill_we_o never asserted.
- Timeout with TIMEOUT=8 and mem_ready_i held 0 → mem_req_o drops after 8 cycles; err_o=1 and stays 1 after later successful transfers; no refill.
- rst_n pulsed low during RD_REQ → all outputs 0 asynchronously; after release the controller is in IDLE and a new miss proceeds normally.
- Saturation with CNT_W=3 → 10 load hits give hit_cnt_o=7; simultaneous load_i & store_i with hit → only a write request is issued and hit_cnt_o is unchanged.
